decode_execute_reg: RTL

DECODE_EXECUTE_REG -- requirements
Module: decode_execute_reg

---
 rtl/decode_execute_reg_pkg.sv | 27 ++
 rtl/decode_execute_reg_if.sv | 49 ++++
 rtl/decode_execute_reg_pipe_reg.sv | 34 +++
 rtl/decode_execute_reg.sv | 97 +++++++++
 4 files changed

// File: rtl/decode_execute_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared pipeline definitions: default datapath and register-index widths,
// control-field widths, the ResultSrc encoding and a saturating increment
// used by the event counters.
// No ports (package).
// ---------------------------------------------------------------------------
package pipeline_pkg;

  localparam int PKG_DATA_W  = 32;
  localparam int PKG_RADDR_W = 5;
  localparam int ALUCTRL_W   = 3;
  localparam int RESSRC_W    = 2;
  localparam int CNT_W       = 32;

  typedef enum logic [RESSRC_W-1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/decode_execute_reg_if.sv
// ---------------------------------------------------------------------------
// decode_execute_reg_if
// Bundles the Decode-side words/controls, the Execute-side registered copies,
// the hazard controls (FlushE, StallE) and the event counters.
//   master : drives D fields, FlushE, StallE; observes E fields and counters
//   slave  : the Decode/Execute register itself
// Parameters: DATA_W (datapath word width), RADDR_W (register index width).
// ---------------------------------------------------------------------------
interface decode_execute_reg_if #(
  parameter int DATA_W  = pipeline_pkg::PKG_DATA_W,
  parameter int RADDR_W = pipeline_pkg::PKG_RADDR_W
) ();

  logic                                FlushE;
  logic                                StallE;

  logic [DATA_W-1:0]                   RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
  logic [RADDR_W-1:0]                  Rs1D, Rs2D, RdD;
  logic                                RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [pipeline_pkg::RESSRC_W-1:0]   ResultSrcD;
  logic [pipeline_pkg::ALUCTRL_W-1:0]  ALUControlD;

  logic [DATA_W-1:0]                   RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
  logic [RADDR_W-1:0]                  Rs1E, Rs2E, RdE;
  logic                                RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [pipeline_pkg::RESSRC_W-1:0]   ResultSrcE;
  logic [pipeline_pkg::ALUCTRL_W-1:0]  ALUControlE;
  logic                                ValidE;
  logic [pipeline_pkg::CNT_W-1:0]      FlushCntE, StallCntE;

  modport master (
    output FlushE, StallE,
    output RD1D, RD2D, PCD, ImmExtD, PCPlus4D, Rs1D, Rs2D, RdD,
    output RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD,
    input  RD1E, RD2E, PCE, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE,
    input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
    input  ValidE, FlushCntE, StallCntE
  );

  modport slave (
    input  FlushE, StallE,
    input  RD1D, RD2D, PCD, ImmExtD, PCPlus4D, Rs1D, Rs2D, RdD,
    input  RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD,
    output RD1E, RD2E, PCE, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE,
    output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
    output ValidE, FlushCntE, StallCntE
  );

endinterface

// File: rtl/decode_execute_reg_pipe_reg.sv
// ---------------------------------------------------------------------------
// pipe_reg
// One pipeline field register with synchronous clear and load enable.
// Priority: rst (active-low, synchronous) > clr > en > hold.
// Ports:
//   clk   in  1      rising-edge clock
//   rst   in  1      synchronous active-low reset
//   en    in  1      load enable
//   clr   in  1      synchronous clear (bubble)
//   i_d   in  WIDTH  next value
//   o_q   out WIDTH  registered value
// ---------------------------------------------------------------------------
module pipe_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst)      r_q <= '0;
    else if (clr)  r_q <= '0;
    else if (en)   r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/decode_execute_reg.sv
// ---------------------------------------------------------------------------
// decode_execute_reg
// Decode -> Execute pipeline register. Every field is registered with one
// cycle of latency; FlushE inserts an all-zero bubble (ValidE=0, register
// indices 0 so the bubble never matches the forwarding comparators), StallE
// holds the current contents. Priority: rst > FlushE > StallE > load.
// Optional feature macro: DE_PERF_CNT_EN -- when defined, FlushCntE/StallCntE
// count flush and stall cycles (saturating); otherwise both read as 0.
// Ports:
//   clk  in  1   rising-edge clock
//   rst  in  1   synchronous active-low reset
//   bus  decode_execute_reg_if.slave
//        FlushE, StallE, *D inputs ; *E outputs, ValidE, FlushCntE, StallCntE
// ---------------------------------------------------------------------------
module decode_execute_reg
  import pipeline_pkg::*;
#(
  parameter int DATA_W  = PKG_DATA_W,
  parameter int RADDR_W = PKG_RADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  decode_execute_reg_if.slave  bus
);

  logic w_en;
  logic w_clr;

  // A simultaneous flush and stall resolves as a flush inside pipe_reg,
  // because clr outranks en there.
  assign w_clr = bus.FlushE;
  assign w_en  = ~bus.StallE;

  // Datapath words
  pipe_reg #(.WIDTH(DATA_W)) u_rd1 (.clk(clk), .rst(rst), .en(w_en), .clr(w_clr),
    .i_d(bus.RD1D), .o_q(bus.RD1E));
  pipe_reg #(.WIDTH(DATA_W)) u_rd2 (.clk(clk), .rst(rst), .en(w_en), .clr(w_clr),
    .i_d(bus.RD2D), .o_q(bus.RD2E));
  pipe_reg #(.WIDTH(DATA_W)) u_pc (.clk(clk), .rst(rst), .en(w_en), .clr(w_clr),
    .i_d(bus.PCD), .o_q(bus.PCE));
  pipe_reg #(.WIDTH(DATA_W)) u_imm (.clk(clk), .rst(rst), .en(w_en), .clr(w_clr),
    .i_d(bus.ImmExtD), .o_q(bus.ImmExtE));
  pipe_reg #(.WIDTH(DATA_W)) u_pc4 (.clk(clk), .rst(rst), .en(w_en), .clr(w_clr),
    .i_d(bus.PCPlus4D), .o_q(bus.PCPlus4E));

  // Register indices
  pipe_reg #(.WIDTH(RADDR_W)) u_rs1 (.clk(clk), .rst(rst), .en(w_en), .clr(w_clr),
    .i_d(bus.Rs1D), .o_q(bus.Rs1E));
  pipe_reg #(.WIDTH(RADDR_W)) u_rs2 (.clk(clk), .rst(rst), .en(w_en), .clr(w_clr),
    .i_d(bus.Rs2D), .o_q(bus.Rs2E));
  pipe_reg #(.WIDTH(RADDR_W)) u_rd (.clk(clk), .rst(rst), .en(w_en), .clr(w_clr),
    .i_d(bus.RdD), .o_q(bus.RdE));

  // Control
  pipe_reg #(.WIDTH(1)) u_regwr (.clk(clk), .rst(rst), .en(w_en), .clr(w_clr),
    .i_d(bus.RegWriteD), .o_q(bus.RegWriteE));
  pipe_reg #(.WIDTH(1)) u_memwr (.clk(clk), .rst(rst), .en(w_en), .clr(w_clr),
    .i_d(bus.MemWriteD), .o_q(bus.MemWriteE));
  pipe_reg #(.WIDTH(1)) u_jump (.clk(clk), .rst(rst), .en(w_en), .clr(w_clr),
    .i_d(bus.JumpD), .o_q(bus.JumpE));
  pipe_reg #(.WIDTH(1)) u_branch (.clk(clk), .rst(rst), .en(w_en), .clr(w_clr),
    .i_d(bus.BranchD), .o_q(bus.BranchE));
  pipe_reg #(.WIDTH(1)) u_alusrc (.clk(clk), .rst(rst), .en(w_en), .clr(w_clr),
    .i_d(bus.ALUSrcD), .o_q(bus.ALUSrcE));
  pipe_reg #(.WIDTH(RESSRC_W)) u_ressrc (.clk(clk), .rst(rst), .en(w_en), .clr(w_clr),
    .i_d(bus.ResultSrcD), .o_q(bus.ResultSrcE));
  pipe_reg #(.WIDTH(ALUCTRL_W)) u_aluctl (.clk(clk), .rst(rst), .en(w_en), .clr(w_clr),
    .i_d(bus.ALUControlD), .o_q(bus.ALUControlE));

  // Valid bit: every load carries a real instruction, bubbles and reset clear it.
  pipe_reg #(.WIDTH(1)) u_valid (.clk(clk), .rst(rst), .en(w_en), .clr(w_clr),
    .i_d(1'b1), .o_q(bus.ValidE));

`ifdef DE_PERF_CNT_EN
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  // A flush+stall cycle counts only as a flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_flush_cnt <= '0;
      r_stall_cnt <= '0;
    end else if (bus.FlushE) begin
      r_flush_cnt <= sat_inc(r_flush_cnt);
    end else if (bus.StallE) begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign bus.FlushCntE = r_flush_cnt;
  assign bus.StallCntE = r_stall_cnt;
`else
  assign bus.FlushCntE = '0;
  assign bus.StallCntE = '0;
`endif

endmodule
